v_merge_seq: RTL and testbench
==============================

V_MERGE_SEQ -- requirements
Module: v_merge_seq

Interface
REQ-001 The block SHALL have parameters REQ_DATA_WIDTH, default 64, operand/beat width in bits (8 bytes per beat).
REQ-002 The block SHALL have parameters REQ_ADDR_WIDTH, default 32, destination address width.
REQ-003 The block SHALL have parameters SEW_WIDTH, default 2, element-width code width.
REQ-004 The block SHALL have parameters MASK_WIDTH, default 8, byte-mask width (one bit per data byte).
REQ-005 The block SHALL have parameters VL_WIDTH, default 7, vector-length field width.
REQ-006 The block SHALL have port clk  in  1  single clock, all logic on posedge.
REQ-007 The block SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-008 The block SHALL have ports cmd_valid in 1 / cmd_ready out 1  command handshake.
REQ-009 The block SHALL have ports cmd_addr  in  REQ_ADDR_WIDTH  destination base address (beat 0).
REQ-010 The block SHALL have ports cmd_vl  in  VL_WIDTH  element count; cmd_sew in SEW_WIDTH  0=8b,1=16b,2=32b,3=64b.
REQ-011 The block SHALL have ports cmd_v0  in  64  v0 mask bits, bit i governs element i; cmd_vm in 1  1=unmasked (all body elements select vec1).
REQ-012 The block SHALL have ports op_valid in 1 / op_ready out 1 / op_vec0, op_vec1 in REQ_DATA_WIDTH  operand beat stream.
REQ-013 The block SHALL have ports out_valid out 1, out_addr out REQ_ADDR_WIDTH, out_mask out MASK_WIDTH, out_vec0/out_vec1 out REQ_DATA_WIDTH  beat to merge stage (no backpressure).
REQ-014 The block SHALL have ports busy out 1 (command in progress), done out 1 (one-cycle completion pulse).

Function
REQ-015 FSM states SHALL be IDLE and RUN; cmd_ready=1 only in IDLE; op_ready=1 only in RUN.
REQ-016 IDLE->RUN on cmd_valid&cmd_ready with cmd_vl>0; command fields latched; beat counter cleared.
REQ-017 cmd_vl>64 SHALL saturate to 64; cmd_vl=0 SHALL stay IDLE, emit no beat, and pulse done the cycle after acceptance.
REQ-018 Elements per beat epb = 8>>sew; total beats = ceil(vl/epb); beat k covers elements k*epb .. k*epb+epb-1.
REQ-019 Each op_valid&op_ready SHALL register one output beat next cycle: out_valid=1, out_vec0/out_vec1 = operands, out_addr = base+k (modulo 2^REQ_ADDR_WIDTH).
REQ-020 out_mask: element e's bit (v0[e], or 1 if vm) SHALL be replicated over its (1<<sew) bytes; elements with e>=vl (tail) SHALL give 0 bytes.
REQ-021 In cycles with no handshake, out_valid=0 and out_addr/out_mask/out_vec0/out_vec1 SHALL be 0.
REQ-022 op_valid low in RUN SHALL stall the counter without output; no state change.
REQ-023 On the last beat's handshake the FSM SHALL return to IDLE; done SHALL pulse in the same cycle as that beat's out_valid.
REQ-024 A new command SHALL be acceptable the cycle after RUN->IDLE; back-to-back commands yield no overlap of beats.
REQ-025 busy = (state==RUN); op_vec inputs in IDLE SHALL be ignored.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, cmd_ready=1 after release, and all outputs (out_*, done, busy, op_ready) to 0.
REQ-027 Reset mid-command SHALL discard the partial command; no further beats or done for it.

Verification
REQ-028 sew=0, vl=8, v0=0xA5, vm=0, addr=0x100, one op beat -> one out beat: addr 0x100, mask 0xA5, done with it.
REQ-029 sew=1, vl=6, v0=0b101101 -> beat0 addr base, mask 0xF3; beat1 addr base+1, mask 0x0C; done on beat1.
REQ-030 sew=2, vl=3, vm=1 -> masks 0xFF then 0x0F; sew=3, vl=64 -> 64 beats, addr base..base+63, mask 0xFF/0x00 per v0 bit.
REQ-031 vl=0 -> no out_valid, done one cycle after acceptance; cmd_vl=100, sew=3 -> exactly 64 beats.
REQ-032 op_valid toggled 1,0,0,1 during a 2-beat command -> out beats only after handshakes, counter held, correct addr sequence.
REQ-033 rst_n pulsed low after beat 1 of 4 -> all outputs 0 at once, no done; fresh command then completes normally.

Source files
------------

// File: rtl/v_merge_seq.sv
// v_merge_seq: sequencer for a masked vector merge.
//
// Accepts one command (base address, element count, element width, v0 mask,
// vm flag) and then consumes one operand beat per op handshake. Each accepted
// beat is re-emitted one cycle later with its destination address and a
// per-byte select mask for the downstream merge stage.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   cmd_valid / cmd_ready   command handshake (ready only while idle)
//   cmd_addr, cmd_vl,       destination base, element count (saturates at 64),
//   cmd_sew, cmd_v0, cmd_vm element width code, v0 mask bits, unmasked flag
//   op_valid / op_ready     operand beat handshake (ready only while running)
//   op_vec0, op_vec1        operand beat data
//   out_valid, out_addr,    registered output beat; all fields are zero when
//   out_mask, out_vec0/1    no beat is presented; no backpressure
//   busy, done              command in progress; one-cycle completion pulse
//   dbg_state               current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake rule: a transfer happens on a rising clock edge where both valid
// and ready are high; valid may be raised without waiting for ready, and the
// data accompanying valid is held until the transfer edge.

module v_merge_seq #(
    parameter int REQ_DATA_WIDTH = 64,
    parameter int REQ_ADDR_WIDTH = 32,
    parameter int SEW_WIDTH      = 2,
    parameter int MASK_WIDTH     = 8,
    parameter int VL_WIDTH       = 7
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [REQ_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [VL_WIDTH-1:0]       cmd_vl,
    input  logic [SEW_WIDTH-1:0]      cmd_sew,
    input  logic [63:0]               cmd_v0,
    input  logic                      cmd_vm,
    input  logic                      op_valid,
    output logic                      op_ready,
    input  logic [REQ_DATA_WIDTH-1:0] op_vec0,
    input  logic [REQ_DATA_WIDTH-1:0] op_vec1,
    output logic                      out_valid,
    output logic [REQ_ADDR_WIDTH-1:0] out_addr,
    output logic [MASK_WIDTH-1:0]     out_mask,
    output logic [REQ_DATA_WIDTH-1:0] out_vec0,
    output logic [REQ_DATA_WIDTH-1:0] out_vec1,
    output logic                      busy,
    output logic                      done,
    output logic                      dbg_state
);

    // One spare bit so "element index + elements per beat" never wraps.
    localparam int ELEM_W = VL_WIDTH + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [REQ_ADDR_WIDTH-1:0] r_addr;     // address of the next beat
    logic [VL_WIDTH-1:0]       r_vl;
    logic [SEW_WIDTH-1:0]      r_sew;
    logic [63:0]               r_v0;
    logic                      r_vm;
    logic [ELEM_W-1:0]         r_elem;     // first element index of the next beat

    logic                      r_out_valid;
    logic [REQ_ADDR_WIDTH-1:0] r_out_addr;
    logic [MASK_WIDTH-1:0]     r_out_mask;
    logic [REQ_DATA_WIDTH-1:0] r_out_vec0;
    logic [REQ_DATA_WIDTH-1:0] r_out_vec1;
    logic                      r_done;

    logic                      w_cmd_fire;
    logic                      w_op_fire;
    logic [VL_WIDTH-1:0]       w_vl_sat;
    logic [ELEM_W-1:0]         w_epb;
    logic                      w_last;
    logic [MASK_WIDTH-1:0]     w_mask;
    logic [ELEM_W-1:0]         w_byte_elem [MASK_WIDTH];

    assign cmd_ready = (r_state == ST_IDLE);
    assign op_ready  = (r_state == ST_RUN);
    assign busy      = (r_state == ST_RUN);
    assign dbg_state = r_state;

    assign w_cmd_fire = cmd_valid & cmd_ready;
    assign w_op_fire  = op_valid & op_ready;

    // Commands longer than the 64-entry v0 register are clipped to 64 elements.
    assign w_vl_sat = (cmd_vl > VL_WIDTH'(64)) ? VL_WIDTH'(64) : cmd_vl;

    // Elements per beat shrink as the element width grows.
    assign w_epb  = ELEM_W'(MASK_WIDTH >> r_sew);
    assign w_last = ((r_elem + w_epb) >= {1'b0, r_vl});

    // Each byte inherits the select bit of the element it belongs to; bytes of
    // elements at or beyond vl (the tail) are never selected.
    always_comb begin
        w_mask = '0;
        for (int b = 0; b < MASK_WIDTH; b++) begin
            w_byte_elem[b] = r_elem + ELEM_W'(b >> r_sew);
            if (w_byte_elem[b] < {1'b0, r_vl}) begin
                w_mask[b] = r_vm | r_v0[w_byte_elem[b][5:0]];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_fire && (w_vl_sat != '0)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_op_fire && w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_vl        <= '0;
            r_sew       <= '0;
            r_v0        <= '0;
            r_vm        <= 1'b0;
            r_elem      <= '0;
            r_out_valid <= 1'b0;
            r_out_addr  <= '0;
            r_out_mask  <= '0;
            r_out_vec0  <= '0;
            r_out_vec1  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // A zero-length command completes on its own acceptance.
            r_done <= (w_cmd_fire && (w_vl_sat == '0)) || (w_op_fire && w_last);

            r_out_valid <= w_op_fire;
            r_out_addr  <= w_op_fire ? r_addr  : '0;
            r_out_mask  <= w_op_fire ? w_mask  : '0;
            r_out_vec0  <= w_op_fire ? op_vec0 : '0;
            r_out_vec1  <= w_op_fire ? op_vec1 : '0;

            if (w_cmd_fire) begin
                r_addr <= cmd_addr;
                r_vl   <= w_vl_sat;
                r_sew  <= cmd_sew;
                r_v0   <= cmd_v0;
                r_vm   <= cmd_vm;
                r_elem <= '0;
            end else if (w_op_fire) begin
                r_addr <= r_addr + REQ_ADDR_WIDTH'(1);
                r_elem <= r_elem + w_epb;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign out_mask  = r_out_mask;
    assign out_vec0  = r_out_vec0;
    assign out_vec1  = r_out_vec1;
    assign done      = r_done;

endmodule

// File: tb/tb_v_merge_seq.sv
// Testbench for v_merge_seq: drives commands and operand beats, predicts
// every output beat with an independent mask/address model, and compares the
// DUT output stream against the predicted queue.

module tb_v_merge_seq;

    localparam int DW     = 64;
    localparam int AW     = 32;
    localparam int BEAT_W = AW + 8 + DW + DW + 1;   // {addr, mask, vec0, vec1, done}

    // ---------------- clock / reset ----------------
    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic [6:0]    cmd_vl;
    logic [1:0]    cmd_sew;
    logic [63:0]   cmd_v0;
    logic          cmd_vm;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op_vec0;
    logic [DW-1:0] op_vec1;
    logic          out_valid;
    logic [AW-1:0] out_addr;
    logic [7:0]    out_mask;
    logic [DW-1:0] out_vec0;
    logic [DW-1:0] out_vec1;
    logic          busy;
    logic          done;
    logic          dbg_state;

    v_merge_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_vl    (cmd_vl),
        .cmd_sew   (cmd_sew),
        .cmd_v0    (cmd_v0),
        .cmd_vm    (cmd_vm),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_vec0   (op_vec0),
        .op_vec1   (op_vec1),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_mask  (out_mask),
        .out_vec0  (out_vec0),
        .out_vec1  (out_vec1),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int                n_compared     = 0;
    int                n_mismatched   = 0;
    int                zero_done_req  = 0;   // zero-length commands accepted
    int                zero_done_seen = 0;   // their done pulses observed
    logic [BEAT_W-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Byte mask for beat k: byte b belongs to element k*epb + b/bpe.
    function automatic logic [7:0] model_mask(input int k, input int vl, input int sew,
                                              input logic [63:0] v0, input logic vm);
        int bpe;
        int epb;
        int e;
        bpe = 1 << sew;
        epb = 8 / bpe;
        model_mask = 8'h00;
        for (int b = 0; b < 8; b++) begin
            e = k * epb + b / bpe;
            if (e < vl) model_mask[b] = vm ? 1'b1 : v0[e];
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [BEAT_W-1:0] e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_addr", out_addr, e[BEAT_W-1 -: AW]);
                check_eq("out_mask", out_mask, e[BEAT_W-AW-1 -: 8]);
                check_eq("out_vec0", out_vec0, e[2*DW:DW+1]);
                check_eq("out_vec1", out_vec1, e[DW:1]);
                check_eq("beat_done", done, e[0]);
            end
        end else begin
            check_eq("idle_out_zero", {63'd0, |{out_addr, out_mask, out_vec0, out_vec1}}, 64'd0);
            if (zero_done_req != zero_done_seen) begin
                check_eq("vl0_done", done, 64'd1);
                zero_done_seen++;
            end else begin
                check_eq("idle_done", done, 64'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cmd_ready();
        int t;
        t = 0;
        while (!cmd_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("cmd_ready_wait", cmd_ready, 64'd1);
    endtask

    task automatic wait_op_ready();
        int t;
        t = 0;
        while (!op_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq("op_ready_wait", op_ready, 64'd1);
    endtask

    // gap_mode: 0 = operands back-to-back, 1 = random idle cycles,
    //           2 = two idle cycles before beat 1 (valid pattern 1,0,0,1)
    task automatic run_cmd(input logic [AW-1:0] addr, input int vl, input int sew,
                           input logic [63:0] v0, input logic vm, input int gap_mode);
        int            eff;
        int            epb;
        int            nbeats;
        int            gap;
        logic [DW-1:0] d0 [64];
        logic [DW-1:0] d1 [64];
        logic [AW-1:0] a;
        eff    = (vl > 64) ? 64 : vl;
        epb    = 8 >> sew;
        nbeats = (eff + epb - 1) / epb;
        for (int k = 0; k < nbeats; k++) begin
            d0[k] = {$urandom, $urandom};
            d1[k] = {$urandom, $urandom};
            a     = addr + AW'(k);
            exp_q.push_back({a, model_mask(k, eff, sew, v0, vm), d0[k], d1[k], (k == nbeats - 1)});
        end

        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_vl    = 7'(vl);
        cmd_sew   = 2'(sew);
        cmd_v0    = v0;
        cmd_vm    = vm;
        wait_cmd_ready();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_v0    = {$urandom, $urandom};

        if (eff == 0) begin
            zero_done_req++;
            check_eq("vl0_stays_idle", busy, 64'd0);
        end else begin
            check_eq("busy_in_run", busy, 64'd1);
        end

        for (int k = 0; k < nbeats; k++) begin
            if (gap_mode == 2) gap = (k == 1) ? 2 : 0;
            else if (gap_mode == 1) gap = $urandom_range(0, 2);
            else gap = 0;
            repeat (gap) begin
                op_valid = 1'b0;
                op_vec0  = {$urandom, $urandom};
                @(posedge clk); #1;
            end
            op_valid = 1'b1;
            op_vec0  = d0[k];
            op_vec1  = d1[k];
            wait_op_ready();
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        check_eq("idle_after_cmd", cmd_ready, 64'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [DW-1:0] rd0;
        logic [DW-1:0] rd1;
        logic [63:0]   v0;

        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_vl    = '0;
        cmd_sew   = '0;
        cmd_v0    = '0;
        cmd_vm    = 1'b0;
        op_valid  = 1'b0;
        op_vec0   = '0;
        op_vec1   = '0;

        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 64'd0);
        check_eq("rst_done", done, 64'd0);
        check_eq("rst_busy", busy, 64'd0);
        check_eq("rst_op_ready", op_ready, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1 rst_n = 1'b1;
        check_eq("rst_cmd_ready", cmd_ready, 64'd1);

        // Operand traffic while idle must be ignored.
        repeat (3) begin
            op_valid = 1'b1;
            op_vec0  = {$urandom, $urandom};
            op_vec1  = {$urandom, $urandom};
            check_eq("idle_op_ready", op_ready, 64'd0);
            @(posedge clk); #1;
        end
        op_valid = 1'b0;

        run_cmd(32'h0000_0100, 8, 0, 64'hA5, 1'b0, 0);
        run_cmd(32'h0000_0200, 6, 1, 64'b101101, 1'b0, 0);
        run_cmd(32'h0000_0300, 3, 2, {$urandom, $urandom}, 1'b1, 0);
        run_cmd(32'h0000_1000, 64, 3, {$urandom, $urandom}, 1'b0, 1);
        run_cmd(32'h0000_0400, 0, 1, 64'hFF, 1'b0, 0);
        run_cmd(32'h0000_2000, 100, 3, {$urandom, $urandom}, 1'b0, 0);
        run_cmd(32'h0000_0500, 16, 0, 64'h00F0_0F00, 1'b0, 2);
        run_cmd(32'hFFFF_FFFE, 32, 2, {$urandom, $urandom}, 1'b0, 1);
        run_cmd(32'h0000_0600, 5, 2, 64'h15, 1'b0, 0);

        // Reset after the first beat of a four-beat command.
        v0  = 64'hB;
        rd0 = {$urandom, $urandom};
        rd1 = {$urandom, $urandom};
        exp_q.push_back({32'h0000_3000, model_mask(0, 4, 3, v0, 1'b0), rd0, rd1, 1'b0});
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0000_3000;
        cmd_vl    = 7'd4;
        cmd_sew   = 2'd3;
        cmd_v0    = v0;
        cmd_vm    = 1'b0;
        wait_cmd_ready();
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        op_valid  = 1'b1;
        op_vec0   = rd0;
        op_vec1   = rd1;
        wait_op_ready();
        @(posedge clk); #1;
        op_vec0 = {$urandom, $urandom};
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 64'd0);
        check_eq("midrst_done", done, 64'd0);
        check_eq("midrst_busy", busy, 64'd0);
        check_eq("midrst_op_ready", op_ready, 64'd0);
        check_eq("midrst_out_mask", out_mask, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst_n    = 1'b1;
        op_valid = 1'b0;
        check_eq("midrst_cmd_ready", cmd_ready, 64'd1);
        repeat (3) @(posedge clk); #1;
        run_cmd(32'h0000_4000, 4, 3, v0, 1'b0, 0);

        // Randomised back-to-back commands.
        for (int i = 0; i < 20; i++) begin
            run_cmd($urandom, $urandom_range(0, 100), $urandom_range(0, 3),
                    {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1);
        end

        repeat (5) @(posedge clk); #1;
        check_eq("queue_empty", exp_q.size(), 64'd0);
        check_eq("vl0_done_count", zero_done_seen, zero_done_req);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_compared);
        $fatal(1, "watchdog expired");
    end

endmodule
